ql_rtc_timer: RTL

Parametrised successor to the fixed 48-bit free-running RTC counter. Runs on the 65536 Hz RTC clock and keeps a 16-bit fractional-second counter plus a SEC_W-bit seconds counter. Provides CPU load/readback with atomic snapshot, and NUM_ALARMS compare channels with one-shot or periodic mode and sticky interrupt pending bits. Sits beside the ZX8302 register decode; bus strobes arrive already synchronised to clk64k.

---
 rtl/ql_rtc_pkg.sv | 36 +++
 rtl/ql_rtc_alarm.sv | 102 ++++++++++
 rtl/ql_rtc_timer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ql_rtc_pkg.sv
// ql_rtc_pkg
// Purpose : shared constants for the RTC timer slice: register addresses,
//           control bit positions, fractional width and calibration fields.
// Ports   : none (package).
// Options : RTC_CALIB_EN enables the CALIB register in ql_rtc_timer.
package ql_rtc_pkg;

   localparam int FRAC_W = 16;

   localparam logic [3:0] ADDR_SEC_HI   = 4'd0;
   localparam logic [3:0] ADDR_SEC_LO   = 4'd1;
   localparam logic [3:0] ADDR_FRAC     = 4'd2;
   localparam logic [3:0] ADDR_CTRL     = 4'd3;
   localparam logic [3:0] ADDR_IRQ      = 4'd4;
   localparam logic [3:0] ADDR_CALIB    = 4'd5;
   localparam logic [3:0] ADDR_ALM_BASE = 4'd8;

   localparam int CTRL_RUN_BIT = 0;

   localparam int ALM_EN_BIT       = 0;
   localparam int ALM_PERIODIC_BIT = 1;
   localparam int ALM_IRQEN_BIT    = 2;

   localparam int CALIB_DIR_BIT = 15;
   localparam int CALIB_N_LSB   = 0;
   localparam int CALIB_N_W     = 8;

   // Register selected inside one alarm channel's 4-word window.
   typedef enum logic [1:0] {
      ALM_REG_HI     = 2'd0,
      ALM_REG_LO     = 2'd1,
      ALM_REG_CTRL   = 2'd2,
      ALM_REG_PERIOD = 2'd3
   } almReg_e;

endpackage

// File: rtl/ql_rtc_alarm.sv
// ql_rtc_alarm
// Purpose : one alarm compare channel. Holds the compare value, reload
//           period and control bits, flags a match when the seconds counter
//           ticks onto the compare value, and reloads or disarms itself.
// Ports   : clk64k, reset      - RTC clock, async active-high reset
//           i_tick             - seconds counter advances by tick this edge
//           i_secNext          - seconds value taking effect on this edge
//           i_wrSel, i_regSel  - CPU write to this channel and which word
//           i_wdata            - CPU write data
//           o_rdata            - readback of the word picked by i_regSel
//           o_irqEn            - channel interrupt enable
//           o_setPending       - match on this edge (combinational)
module ql_rtc_alarm
   import ql_rtc_pkg::*;
#(
   parameter int SEC_W = 32
) (
   input  logic             clk64k,
   input  logic             reset,
   input  logic             i_tick,
   input  logic [SEC_W-1:0] i_secNext,
   input  logic             i_wrSel,
   input  almReg_e          i_regSel,
   input  logic [15:0]      i_wdata,
   output logic [15:0]      o_rdata,
   output logic             o_irqEn,
   output logic             o_setPending
);

   logic [SEC_W-1:0] r_cmp;
   logic [15:0]      r_period;
   logic             r_en;
   logic             r_periodic;
   logic             r_irqEn;

   logic [31:0]      w_cmpWide;
   logic [31:0]      w_cmpHiLoad;
   logic [31:0]      w_cmpLoLoad;
   logic             w_match;

   // The compare value is handled as a zero-extended 32-bit word so the
   // HI/LO halves line up with the CPU view whatever SEC_W is.
   assign w_cmpWide   = 32'(r_cmp);
   assign w_cmpHiLoad = {i_wdata, w_cmpWide[15:0]};
   assign w_cmpLoLoad = {w_cmpWide[31:16], i_wdata};

   // Only tick-driven second changes can match; CPU loads never reach here.
   assign w_match      = i_tick && r_en && (i_secNext == r_cmp);
   assign o_setPending = w_match;
   assign o_irqEn      = r_irqEn;

   // Match handling first, CPU write afterwards so a same-cycle CPU write
   // to HI/LO/CTRL takes priority over the reload/disarm of that register.
   // A zero period in periodic mode falls back to one-shot behaviour.
   always_ff @(posedge clk64k or posedge reset) begin
      if (reset) begin
         r_cmp      <= '0;
         r_period   <= '0;
         r_en       <= 1'b0;
         r_periodic <= 1'b0;
         r_irqEn    <= 1'b0;
      end else begin
         if (w_match) begin
            if (r_periodic && (r_period != 16'd0)) begin
               r_cmp <= r_cmp + SEC_W'(r_period);
            end else begin
               r_en <= 1'b0;
            end
         end
         if (i_wrSel) begin
            case (i_regSel)
               ALM_REG_HI:     r_cmp <= w_cmpHiLoad[SEC_W-1:0];
               ALM_REG_LO:     r_cmp <= w_cmpLoLoad[SEC_W-1:0];
               ALM_REG_CTRL: begin
                  r_en       <= i_wdata[ALM_EN_BIT];
                  r_periodic <= i_wdata[ALM_PERIODIC_BIT];
                  r_irqEn    <= i_wdata[ALM_IRQEN_BIT];
               end
               ALM_REG_PERIOD: r_period <= i_wdata;
               default:        r_period <= r_period;
            endcase
         end
      end
   end

   // Readback of the channel word currently addressed.
   always_comb begin
      o_rdata = '0;
      case (i_regSel)
         ALM_REG_HI:     o_rdata = w_cmpWide[31:16];
         ALM_REG_LO:     o_rdata = w_cmpWide[15:0];
         ALM_REG_CTRL: begin
            o_rdata[ALM_EN_BIT]       = r_en;
            o_rdata[ALM_PERIODIC_BIT] = r_periodic;
            o_rdata[ALM_IRQEN_BIT]    = r_irqEn;
         end
         ALM_REG_PERIOD: o_rdata = r_period;
         default:        o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/ql_rtc_timer.sv
// ql_rtc_timer
// Purpose : RTC timer on the 65536 Hz clock. 16-bit fractional counter plus
//           SEC_W-bit seconds counter, CPU load and tear-free snapshot read,
//           NUM_ALARMS compare channels with sticky pending bits and irq.
// Ports   : clk64k, reset          - RTC clock, async active-high reset
//           i_wr, i_rd             - single-cycle bus strobes (clk64k domain)
//           i_addr, i_wdata        - register index and write data
//           o_rdata                - combinational read data for i_addr
//           o_irq_pending          - sticky alarm flags (write-1-to-clear)
//           o_irq                  - registered OR of enabled pending flags
//           o_sec_tick             - one-cycle pulse when seconds advance
// Options : RTC_CALIB_EN adds the CALIB register (addr 5) and the periodic
//           one-count advance/retard of the fractional counter.
module ql_rtc_timer
   import ql_rtc_pkg::*;
#(
   parameter int   SEC_W      = 32,
   parameter int   NUM_ALARMS = 2,
   parameter logic RUN_RST    = 1'b1
) (
   input  logic                  clk64k,
   input  logic                  reset,
   input  logic                  i_wr,
   input  logic                  i_rd,
   input  logic [3:0]            i_addr,
   input  logic [15:0]           i_wdata,
   output logic [15:0]           o_rdata,
   output logic [NUM_ALARMS-1:0] o_irq_pending,
   output logic                  o_irq,
   output logic                  o_sec_tick
);

   logic [FRAC_W-1:0]     r_frac;
   logic [SEC_W-1:0]      r_sec;
   logic                  r_run;
   logic [15:0]           r_holdHi;
   logic [15:0]           r_snapLo;
   logic [FRAC_W-1:0]     r_snapFrac;
   logic [NUM_ALARMS-1:0] r_pending;
   logic                  r_irq;
   logic                  r_secTick;

   logic                  w_wrSecHi;
   logic                  w_wrSecLo;
   logic                  w_wrFrac;
   logic                  w_wrCtrl;
   logic                  w_wrIrq;
   logic                  w_rdSecHi;
   logic                  w_carry;
   logic                  w_tick;
   logic [SEC_W-1:0]      w_secNext;
   logic [31:0]           w_secWide;
   logic [31:0]           w_loadWide;
   logic [FRAC_W-1:0]     w_fracNext;
   logic [NUM_ALARMS-1:0] w_setPending;
   logic [NUM_ALARMS-1:0] w_clrPending;
   logic [NUM_ALARMS-1:0] w_irqEn;
   logic [15:0]           w_almRdata [NUM_ALARMS];

   assign w_wrSecHi = i_wr && (i_addr == ADDR_SEC_HI);
   assign w_wrSecLo = i_wr && (i_addr == ADDR_SEC_LO);
   assign w_wrFrac  = i_wr && (i_addr == ADDR_FRAC);
   assign w_wrCtrl  = i_wr && (i_addr == ADDR_CTRL);
   assign w_wrIrq   = i_wr && (i_addr == ADDR_IRQ);
   assign w_rdSecHi = i_rd && (i_addr == ADDR_SEC_HI);

   // A carry rolls the second over; a same-edge SEC_LO load overrides it,
   // so the tick (and alarm evaluation) is only seen on genuine carries.
   assign w_carry    = r_run && (r_frac == {FRAC_W{1'b1}});
   assign w_tick     = w_carry && !w_wrSecLo;
   assign w_secNext  = r_sec + SEC_W'(1);
   assign w_secWide  = 32'(r_sec);
   assign w_loadWide = {r_holdHi, i_wdata};

   assign w_clrPending = w_wrIrq ? i_wdata[NUM_ALARMS-1:0] : '0;

`ifdef RTC_CALIB_EN
   logic                 r_calDir;
   logic [CALIB_N_W-1:0] r_calN;
   logic [CALIB_N_W-1:0] r_calCnt;
   logic                 r_calArm;
   logic                 w_wrCalib;
   logic                 w_calAdjust;

   assign w_wrCalib = i_wr && (i_addr == ADDR_CALIB);

   // The adjustment is applied once, early in the second after an armed
   // boundary; staying below FFFE keeps a +2 step from skipping the carry.
   assign w_calAdjust = r_calArm && r_run && (r_frac < 16'hFFFE);

   // Every Nth tick arms one adjustment for the following second. Writing
   // CALIB restarts the boundary count so a new setting starts cleanly.
   always_ff @(posedge clk64k or posedge reset) begin
      if (reset) begin
         r_calDir <= 1'b0;
         r_calN   <= '0;
         r_calCnt <= '0;
         r_calArm <= 1'b0;
      end else if (w_wrCalib) begin
         r_calDir <= i_wdata[CALIB_DIR_BIT];
         r_calN   <= i_wdata[CALIB_N_LSB +: CALIB_N_W];
         r_calCnt <= '0;
         r_calArm <= 1'b0;
      end else begin
         if (w_calAdjust) begin
            r_calArm <= 1'b0;
         end
         if (w_tick && (r_calN != '0)) begin
            if (r_calCnt == r_calN - 8'd1) begin
               r_calCnt <= '0;
               r_calArm <= 1'b1;
            end else begin
               r_calCnt <= r_calCnt + 8'd1;
            end
         end
      end
   end
`endif

   // Next fractional value: free count when running (wraps FFFF->0 on the
   // carry), optional calibration step, then CPU loads which always win.
   always_comb begin
      w_fracNext = r_frac;
      if (r_run) begin
         w_fracNext = r_frac + 16'd1;
`ifdef RTC_CALIB_EN
         if (w_calAdjust) begin
            w_fracNext = r_calDir ? r_frac : r_frac + 16'd2;
         end
`endif
      end
      if (w_wrFrac) begin
         w_fracNext = i_wdata;
      end
      if (w_wrSecLo) begin
         w_fracNext = '0;
      end
   end

   // Counter, run control, load holding register and snapshot capture.
   // The snapshot takes the pre-edge sec/frac, i.e. the same instant whose
   // upper seconds are being returned live on the addr 0 read.
   always_ff @(posedge clk64k or posedge reset) begin
      if (reset) begin
         r_frac     <= '0;
         r_sec      <= '0;
         r_run      <= RUN_RST;
         r_holdHi   <= '0;
         r_snapLo   <= '0;
         r_snapFrac <= '0;
         r_secTick  <= 1'b0;
      end else begin
         r_frac    <= w_fracNext;
         r_secTick <= w_tick;
         if (w_wrSecLo) begin
            r_sec <= w_loadWide[SEC_W-1:0];
         end else if (w_carry) begin
            r_sec <= w_secNext;
         end
         if (w_wrSecHi) begin
            r_holdHi <= i_wdata;
         end
         if (w_wrCtrl) begin
            r_run <= i_wdata[CTRL_RUN_BIT];
         end
         if (w_rdSecHi) begin
            r_snapLo   <= w_secWide[15:0];
            r_snapFrac <= r_frac;
         end
      end
   end

   // Sticky pending flags: a new match beats a concurrent write-1-to-clear.
   // The irq output follows the pending flags one cycle later.
   always_ff @(posedge clk64k or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clrPending) | w_setPending;
         r_irq     <= |(r_pending & w_irqEn);
      end
   end

   // One compare channel per alarm; channel n owns addresses 8+4n..11+4n.
   genvar n;
   generate
      for (n = 0; n < NUM_ALARMS; n++) begin : g_alarm
         localparam logic [3:0] BASE = ADDR_ALM_BASE + 4'(4 * n);
         ql_rtc_alarm #(
            .SEC_W (SEC_W)
         ) u_alarm (
            .clk64k       (clk64k),
            .reset        (reset),
            .i_tick       (w_tick),
            .i_secNext    (w_secNext),
            .i_wrSel      (i_wr && (i_addr[3:2] == BASE[3:2])),
            .i_regSel     (almReg_e'(i_addr[1:0])),
            .i_wdata      (i_wdata),
            .o_rdata      (w_almRdata[n]),
            .o_irqEn      (w_irqEn[n]),
            .o_setPending (w_setPending[n])
         );
      end
   endgenerate

   // Combinational register readback; anything unmapped returns zero.
   always_comb begin
      o_rdata = '0;
      case (i_addr)
         ADDR_SEC_HI: o_rdata = w_secWide[31:16];
         ADDR_SEC_LO: o_rdata = r_snapLo;
         ADDR_FRAC:   o_rdata = r_snapFrac;
         ADDR_CTRL:   o_rdata = {15'd0, r_run};
         ADDR_IRQ:    o_rdata = 16'(r_pending);
`ifdef RTC_CALIB_EN
         ADDR_CALIB:  o_rdata = {r_calDir, 7'd0, r_calN};
`endif
         default: begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
               if (i_addr[3] && (i_addr[2] == k[0])) begin
                  o_rdata = w_almRdata[k];
               end
            end
         end
      endcase
   end

   assign o_irq_pending = r_pending;
   assign o_irq         = r_irq;
   assign o_sec_tick    = r_secTick;

endmodule
